// File: rtl/sb_tx_fifo_sim.sv
// Switchboard transmitter sim model: buffers a valid/ready word stream in a small FIFO
// and drains it into a switchboard queue through the pi_sb_* send hooks.
`timescale 1ns/1ps

package sb_tx_pkg;
    localparam int unsigned DATA_W = 256;
    localparam int unsigned DEST_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              last;
    } sb_word_t;

    // Built-in loopback queue standing in for the switchboard.
    localparam int unsigned LB_DEPTH = 16;
    sb_word_t    lb_mem [LB_DEPTH];
    int unsigned lb_wr = 0;
    int unsigned lb_rd = 0;
    bit          lb_blocked = 1'b0;

    function automatic void pi_sb_tx_init(output int id, input string uri);
        id = (uri.len() != 0) ? 0 : -1;
    endfunction

    function automatic void pi_sb_send(input int id, input bit [255:0] sdata,
                                       input int sdest, input int slast,
                                       output int success);
        success = 0;
        if (id >= 0 && !lb_blocked && (lb_wr - lb_rd) < LB_DEPTH) begin
            lb_mem[4'(lb_wr)] = '{data: sdata, dest: sdest, last: slast[0]};
            lb_wr = lb_wr + 1;
            success = 1;
        end
    endfunction

    // Receiver side of the loopback queue.
    function automatic void sb_recv(output bit got, output sb_word_t w);
        got = (lb_wr != lb_rd);
        w   = '0;
        if (got) begin
            w     = lb_mem[4'(lb_rd)];
            lb_rd = lb_rd + 1;
        end
    endfunction
endpackage

module sb_tx_fifo_sim #(
    parameter int DEPTH              = 4,
    parameter int READY_MODE_DEFAULT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [255:0]                 data,
    input  logic [31:0]                  dest,
    input  logic                         last,
    input  logic                         valid,
    output logic                         ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [31:0]                  sent_count
);
    import sb_tx_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Simulation-side configuration; deliberately outside the reset domain.
    int id         = -1;
    int ready_mode = READY_MODE_DEFAULT;

    function void init(input string uri);
        pi_sb_tx_init(id, uri);
    endfunction

    function void set_ready_mode(input int value);
        ready_mode = value;
    endfunction

    sb_word_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            can_send;

    assign push     = valid && ready;
    assign can_send = (level != '0) && (id != -1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Payload storage needs no reset: contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sb_word_t'({data, dest, last});
    end

    // Drain attempt uses the head as it stood before this edge, so a word pushed
    // into an empty FIFO cannot leave on its own push edge.
    always_ff @(posedge clk or posedge rst) begin : drain
        int ok;
        if (rst) begin
            ready      <= 1'b0;
            level      <= '0;
            sent_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (can_send)
                pi_sb_send(id, mem[rd_ptr].data, 32'(mem[rd_ptr].dest),
                           32'(mem[rd_ptr].last), ok);
            if (can_send && ok != 0) begin
                rd_ptr     <= ptr_inc(rd_ptr);
                sent_count <= sent_count + 32'd1;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            level <= level + LW'(push) - LW'(can_send && ok != 0);
            if (level + LW'(push) - LW'(can_send && ok != 0) == LW'(DEPTH)) begin
                ready <= 1'b0;
            end else begin
                case (ready_mode)
                    0:       ready <= ~ready;
                    2:       ready <= (($random % 2) == 1);
                    default: ready <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sb_tx_fifo_sim.sv
// Scoreboard bench for sb_tx_fifo_sim: accepted words are queued as expectations and
// a negedge monitor compares everything that arrives in the loopback switchboard queue.
`timescale 1ns/1ps

module tb_sb_tx_fifo_sim;
    import sb_tx_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] data = '0;
    logic [31:0]  dest = '0;
    logic         last = 1'b0;
    logic         valid = 1'b0;
    logic         ready;
    logic [2:0]   level;
    logic [31:0]  sent_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    sb_word_t exp_q[$];

    sb_tx_fifo_sim #(.DEPTH(4), .READY_MODE_DEFAULT(0)) dut (
        .clk(clk), .rst(rst), .data(data), .dest(dest), .last(last), .valid(valid),
        .ready(ready), .level(level), .sent_count(sent_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic sb_word_t mk(input int i, input bit l);
        sb_word_t w;
        w.data = {8{32'(i) ^ 32'hC0DE_0000}};
        w.dest = 32'(i);
        w.last = l;
        return w;
    endfunction

    // Monitor: every word delivered to the queue must match the oldest expectation.
    always @(negedge clk) begin : mon
        bit       got;
        sb_word_t w;
        sb_word_t e;
        sb_recv(got, w);
        while (got) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got dest %0d with nothing expected", w.dest);
            end else begin
                e = exp_q.pop_front();
                if (w !== e) begin
                    miscompares++;
                    $display("FAIL queue_word: got dest %0d last %0b data %h expected dest %0d last %0b data %h",
                             w.dest, w.last, w.data[31:0], e.dest, e.last, e.data[31:0]);
                end
            end
            sb_recv(got, w);
        end
    end

    // Holds valid high and offers words base..base+n-1; an accept is predicted when
    // ready is high at the negedge preceding the edge.
    task automatic drive(input int base, input int n, input int last_idx, input int max_cyc,
                         output int k, output int first_c, output int last_c, output int lows);
        sb_word_t w;
        k = 0; first_c = -1; last_c = -1; lows = 0;
        valid = 1'b1;
        for (int c = 0; c < max_cyc && k < n; c++) begin
            w    = mk(base + k, (base + k) == last_idx);
            data = w.data;
            dest = w.dest;
            last = w.last;
            if (ready) begin
                exp_q.push_back(w);
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                k++;
            end else begin
                lows++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k, f, l, lows, sc;
        dut.set_ready_mode(1);
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 0);
        chk("reset_level", 64'(level), 0);
        chk("reset_sent", 64'(sent_count), 0);

        // No init yet: FIFO fills to DEPTH and nothing is sent.
        rst = 1'b0;
        drive(100, 6, -1, 10, k, f, l, lows);
        chk("noid_accepts", k, 4);
        chk("noid_level", 64'(level), 4);
        chk("noid_ready", 64'(ready), 0);
        chk("noid_sent", 64'(sent_count), 0);
        chk("noid_pending", exp_q.size(), 4);
        dut.init("loopback");
        @(negedge clk);
        chk("init_ready", 64'(ready), 1);
        chk("init_level", 64'(level), 3);
        repeat (3) @(negedge clk);
        chk("init_drain_level", 64'(level), 0);
        chk("init_drain_sent", 64'(sent_count), 4);

        // Mode 1 stream of 10 words, last on word 9.
        drive(0, 10, 9, 40, k, f, l, lows);
        chk("m1_accepts", k, 10);
        chk("m1_ready_lows", lows, 0);
        repeat (4) @(negedge clk);
        chk("m1_sent", 64'(sent_count), 14);
        chk("m1_level", 64'(level), 0);
        chk("m1_ready", 64'(ready), 1);
        chk("m1_pending", exp_q.size(), 0);

        // Receiver refuses for 20 cycles: head retried, nothing counted.
        lb_blocked = 1'b1;
        drive(200, 3, -1, 20, k, f, l, lows);
        chk("blk_accepts", k, 3);
        sc = int'(sent_count);
        repeat (20) @(negedge clk);
        chk("blk_sent_held", 64'(sent_count), 64'(sc));
        chk("blk_level", 64'(level), 3);
        lb_blocked = 1'b0;
        repeat (5) @(negedge clk);
        chk("blk_sent_after", 64'(sent_count), 64'(sc + 3));
        chk("blk_level_after", 64'(level), 0);
        chk("blk_pending", exp_q.size(), 0);

        // Asynchronous reset with three words buffered and valid high.
        lb_blocked = 1'b1;
        drive(300, 3, -1, 20, k, f, l, lows);
        chk("rst_pre_level", 64'(level), 3);
        valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ready", 64'(ready), 0);
        chk("rst_async_level", 64'(level), 0);
        chk("rst_async_sent", 64'(sent_count), 0);
        exp_q.delete();
        lb_blocked = 1'b0;
        dut.set_ready_mode(0);
        repeat (3) @(negedge clk);
        chk("rst_hold_sent", 64'(sent_count), 0);
        valid = 1'b0;
        rst   = 1'b0;

        // Mode 0: ready toggles from the first edge after reset release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("m0_toggle", 64'(ready), (i % 2 == 0) ? 1 : 0);
        end
        drive(400, 8, 407, 40, k, f, l, lows);
        chk("m0_accepts", k, 8);
        chk("m0_accept_span", l - f, 14);
        repeat (4) @(negedge clk);
        chk("m0_sent", 64'(sent_count), 8);
        chk("m0_pending", exp_q.size(), 0);

        // Mode 2: random ready, 1000 words in order.
        dut.set_ready_mode(2);
        sc = int'(sent_count);
        drive(1000, 1000, 1999, 20000, k, f, l, lows);
        chk("m2_accepts", k, 1000);
        chk("m2_ready_dropped", 64'(lows > 0), 1);
        repeat (8) @(negedge clk);
        chk("m2_sent", 64'(sent_count), 64'(sc + 1000));
        chk("m2_level", 64'(level), 0);
        chk("m2_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
